clkout_bank: RTL and testbench
==============================

CLKOUT_BANK -- requirements
Module: clkout_bank

Interface
REQ-001 SHALL have parameter CHANNELS, default 6, meaning the number of output channels (1-8).
REQ-002 SHALL have parameter CNT_WIDTH, default 8, meaning the width of the divide, high and phase counters (2-16).
REQ-003 SHALL have parameter DEFAULT_DIVIDE, default 4, meaning the reset divide value for every channel.
REQ-004 SHALL have parameter DEFAULT_HIGH, default 2, meaning the reset high-time in clk cycles for every channel.
REQ-005 SHALL have parameter DEFAULT_PHASE, default 0, meaning the reset phase delay in clk cycles for every channel.
REQ-006 SHALL have parameter LOCK_CYCLES, default 16, meaning the number of cycles in RUN before LOCKED asserts.
REQ-007 SHALL have port clk, input, 1 bit, the single VCO-rate clock; all logic is on its rising edge.
REQ-008 SHALL have port RST, input, 1 bit, synchronous active-low reset.
REQ-009 SHALL have port PWRDWN, input, 1 bit, active-high power-down.
REQ-010 SHALL have port DADDR, input, 7 bits, the reconfiguration register address.
REQ-011 SHALL have port DEN, input, 1 bit, the access strobe.
REQ-012 SHALL have port DWE, input, 1 bit, the write enable qualifying DEN.
REQ-013 SHALL have port DI, input, 16 bits, the write data.
REQ-014 SHALL have port DO, output, 16 bits, the read data.
REQ-015 SHALL have port DRDY, output, 1 bit, the access-complete pulse.
REQ-016 SHALL have port CLKOUT, output, CHANNELS bits, the divided clocks.
REQ-017 SHALL have port LOCKED, output, 1 bit, high when all channels are running the committed configuration.

Function
REQ-018 SHALL use FSM states IDLE, ALIGN, RUN; IDLE->ALIGN on the cycle after RST deasserts with PWRDWN low; ALIGN->RUN when every channel has finished its phase delay; RUN->ALIGN on commit.
REQ-019 SHALL, in ALIGN, hold channel c low for PHASE[c] cycles, then start its period.
REQ-020 SHALL drive channel c high for HIGH[c] cycles and low for DIVIDE[c]-HIGH[c] cycles, repeating with its counter wrapping from DIVIDE[c]-1 to 0.
REQ-021 SHALL clamp values at write time: DIVIDE<2 becomes 2; HIGH=0 becomes 1; HIGH>=DIVIDE becomes DIVIDE-1 (using the post-clamp DIVIDE).
REQ-022 SHALL assert LOCKED after LOCK_CYCLES consecutive RUN cycles, and deassert it on the same cycle the FSM leaves RUN.
REQ-023 SHALL map registers per channel c: address 3c DIVIDE, 3c+1 HIGH, 3c+2 PHASE, each using DI[CNT_WIDTH-1:0]; address 7'h7F is COMMIT.
REQ-024 SHALL make writes update shadow registers only; a write to COMMIT copies all shadows into the active set and forces ALIGN.
REQ-025 SHALL pulse DRDY for exactly one cycle, the cycle after DEN is sampled high.
REQ-026 SHALL, on a read, present the shadow value on DO, zero-extended, in the DRDY cycle; DO SHALL be 0 at all other times.
REQ-027 SHALL ignore DEN while DRDY is high, with no side effect.
REQ-028 SHALL still produce DRDY for unmapped addresses; such writes are discarded and such reads return 0.
REQ-029 SHALL, while PWRDWN is high, drive CLKOUT and LOCKED to 0, hold the FSM in IDLE, and keep the shadow and active registers intact.

Reset
REQ-030 SHALL, with RST low at a clk edge, set CLKOUT=0, LOCKED=0, DRDY=0, DO=0, FSM=IDLE, and all counters to 0.
REQ-031 SHALL, on reset, load the shadow and active registers with DEFAULT_DIVIDE, DEFAULT_HIGH and DEFAULT_PHASE (clamped per REQ-021).
REQ-032 SHALL let reset in the middle of a DRP access abort it with no DRDY.

Configuration
REQ-033 SHALL, with CLKOUT_BANK_DYN_RECONF_EN defined, implement REQ-023 to REQ-028.
REQ-034 SHALL, without CLKOUT_BANK_DYN_RECONF_EN, ignore DADDR, DEN, DWE and DI, tie DRDY and DO to 0, and run the parameter defaults permanently.

Verification
REQ-035 SHALL cover defaults: release RST -> CLKOUT[0] pattern 1100 repeating, and LOCKED high 16 cycles after ALIGN->RUN.
REQ-036 SHALL cover phase: write PHASE[1]=3 then COMMIT -> LOCKED drops next cycle, and CLKOUT[1] rises 3 cycles after CLKOUT[0].
REQ-037 SHALL cover clamping: write DIVIDE[2]=1 and HIGH[2]=9 -> reads return 2 and 1; after COMMIT, CLKOUT[2] toggles every cycle.
REQ-038 SHALL cover the handshake: assert DEN two consecutive cycles -> one DRDY, and the second access is ignored; read of address 7'h50 -> DO=0 with DRDY.
REQ-039 SHALL cover power-down: assert PWRDWN for 10 cycles in RUN -> outputs 0; after release, relock with the same committed values.
REQ-040 SHALL cover the build without the macro: any DRP write -> DRDY stays 0 and outputs are unchanged.

Source files
------------

// File: rtl/clkout_bank.sv
// Clock-output bank: per-channel divide/high/phase counters behind an ALIGN/RUN sequencer.
// Define CLKOUT_BANK_DYN_RECONF_EN to enable the DRP shadow/commit reconfiguration port.
module clkout_bank #(
  parameter int CHANNELS       = 6,
  parameter int CNT_WIDTH      = 8,
  parameter int DEFAULT_DIVIDE = 4,
  parameter int DEFAULT_HIGH   = 2,
  parameter int DEFAULT_PHASE  = 0,
  parameter int LOCK_CYCLES    = 16
) (
  input  logic                clk,
  input  logic                RST,
  input  logic                PWRDWN,
  input  logic [6:0]          DADDR,
  input  logic                DEN,
  input  logic                DWE,
  input  logic [15:0]         DI,
  output logic [15:0]         DO,
  output logic                DRDY,
  output logic [CHANNELS-1:0] CLKOUT,
  output logic                LOCKED
);

  typedef logic [CNT_WIDTH-1:0] cnt_t;
  typedef enum logic [1:0] {IDLE, ALIGN, RUN} state_e;

  function automatic cnt_t clampDiv(input cnt_t v);
    return (v < cnt_t'(2)) ? cnt_t'(2) : v;
  endfunction

  function automatic cnt_t clampHigh(input cnt_t h, input cnt_t d);
    if (h == cnt_t'(0)) return cnt_t'(1);
    if (h >= d) return d - cnt_t'(1);
    return h;
  endfunction

  localparam cnt_t        RST_DIV   = clampDiv(cnt_t'(DEFAULT_DIVIDE));
  localparam cnt_t        RST_HIGH  = clampHigh(cnt_t'(DEFAULT_HIGH), RST_DIV);
  localparam cnt_t        RST_PHASE = cnt_t'(DEFAULT_PHASE);
  localparam logic [15:0] LOCK_MAX  = 16'(LOCK_CYCLES);

  state_e              state_q, state_d;
  cnt_t                divAct   [CHANNELS];
  cnt_t                highAct  [CHANNELS];
  cnt_t                phaseAct [CHANNELS];
  cnt_t                divCnt_q   [CHANNELS];
  cnt_t                phaseCnt_q [CHANNELS];
  logic [CHANNELS-1:0] run_q;
  logic [CHANNELS-1:0] running;
  logic [15:0]         lockCnt_q;
  logic                commit;
  logic                restart;
  logic                unusedInputs;

  assign unusedInputs = ^{DADDR, DEN, DWE, DI};

`ifdef CLKOUT_BANK_DYN_RECONF_EN
  cnt_t        divShd_q   [CHANNELS];
  cnt_t        highShd_q  [CHANNELS];
  cnt_t        phaseShd_q [CHANNELS];
  cnt_t        divAct_q   [CHANNELS];
  cnt_t        highAct_q  [CHANNELS];
  cnt_t        phaseAct_q [CHANNELS];
  logic        drdy_q;
  logic [15:0] do_q;
  logic [15:0] rdData;
  logic        access;

  // A new access is only accepted when the previous one is not completing this cycle
  assign access = DEN && !drdy_q;
  assign commit = access && DWE && (DADDR == 7'h7F);
  assign DRDY   = drdy_q;
  assign DO     = do_q;

  always_comb begin
    rdData = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      divAct[c]   = divAct_q[c];
      highAct[c]  = highAct_q[c];
      phaseAct[c] = phaseAct_q[c];
      if (DADDR == 7'(3*c))     rdData = 16'(divShd_q[c]);
      if (DADDR == 7'(3*c + 1)) rdData = 16'(highShd_q[c]);
      if (DADDR == 7'(3*c + 2)) rdData = 16'(phaseShd_q[c]);
    end
  end

  always_ff @(posedge clk) begin
    if (!RST) begin
      drdy_q <= 1'b0;
      do_q   <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        divShd_q[c]   <= RST_DIV;
        highShd_q[c]  <= RST_HIGH;
        phaseShd_q[c] <= RST_PHASE;
        divAct_q[c]   <= RST_DIV;
        highAct_q[c]  <= RST_HIGH;
        phaseAct_q[c] <= RST_PHASE;
      end
    end else begin
      drdy_q <= access;
      do_q   <= (access && !DWE) ? rdData : '0;
      if (access && DWE) begin
        // HIGH is clamped against the shadow DIVIDE as it stands at write time
        for (int c = 0; c < CHANNELS; c++) begin
          if (DADDR == 7'(3*c))     divShd_q[c]   <= clampDiv(DI[CNT_WIDTH-1:0]);
          if (DADDR == 7'(3*c + 1)) highShd_q[c]  <= clampHigh(DI[CNT_WIDTH-1:0], divShd_q[c]);
          if (DADDR == 7'(3*c + 2)) phaseShd_q[c] <= DI[CNT_WIDTH-1:0];
          if (commit) begin
            divAct_q[c]   <= divShd_q[c];
            highAct_q[c]  <= highShd_q[c];
            phaseAct_q[c] <= phaseShd_q[c];
          end
        end
      end
    end
  end
`else
  assign commit = 1'b0;
  assign DRDY   = 1'b0;
  assign DO     = '0;

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      divAct[c]   = RST_DIV;
      highAct[c]  = RST_HIGH;
      phaseAct[c] = RST_PHASE;
    end
  end
`endif

  // A channel runs once its phase delay has elapsed; the phase count is only live in ALIGN
  always_comb begin
    CLKOUT = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      running[c] = run_q[c] || ((state_q == ALIGN) && (phaseCnt_q[c] == phaseAct[c]));
      CLKOUT[c]  = !PWRDWN && running[c] && (divCnt_q[c] < highAct[c]);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = ALIGN;
      ALIGN:   if (&running) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase
    if (commit) state_d = ALIGN;
    if (PWRDWN) state_d = IDLE;
  end

  assign restart = (state_d == IDLE) || ((state_d == ALIGN) && ((state_q != ALIGN) || commit));
  assign LOCKED  = !PWRDWN && (state_q == RUN) && (lockCnt_q == LOCK_MAX);

  always_ff @(posedge clk) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!RST || restart) begin
      run_q <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        divCnt_q[c]   <= '0;
        phaseCnt_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (running[c]) begin
          run_q[c]    <= 1'b1;
          divCnt_q[c] <= (divCnt_q[c] >= divAct[c] - cnt_t'(1)) ? '0 : divCnt_q[c] + cnt_t'(1);
        end else begin
          phaseCnt_q[c] <= phaseCnt_q[c] + cnt_t'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!RST || (state_q != RUN) || (state_d != RUN)) lockCnt_q <= '0;
    else if (lockCnt_q != LOCK_MAX)                   lockCnt_q <= lockCnt_q + 16'd1;
  end

endmodule

// File: tb/tb_clkout_bank.sv
// Directed self-checking bench for clkout_bank; DRP scenarios run when CLKOUT_BANK_DYN_RECONF_EN is defined.
module tb_clkout_bank;
  localparam int CH = 6;

  logic          clk = 1'b0;
  logic          RST, PWRDWN, DEN, DWE;
  logic [6:0]    DADDR;
  logic [15:0]   DI, DO;
  logic          DRDY, LOCKED;
  logic [CH-1:0] CLKOUT;

  int nChecks = 0;
  int nFails  = 0;
  int tAlign  = 0;
  int mDiv   [CH];
  int mHigh  [CH];
  int mPhase [CH];

  always #5 clk = ~clk;

  clkout_bank dut (
    .clk(clk), .RST(RST), .PWRDWN(PWRDWN), .DADDR(DADDR), .DEN(DEN), .DWE(DWE),
    .DI(DI), .DO(DO), .DRDY(DRDY), .CLKOUT(CLKOUT), .LOCKED(LOCKED)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    tAlign++;
  endtask

  // Expected output pattern, counted from the first ALIGN cycle
  function automatic logic [CH-1:0] expClk(input int t);
    logic [CH-1:0] r;
    r = '0;
    for (int c = 0; c < CH; c++)
      if (t >= mPhase[c] && ((t - mPhase[c]) % mDiv[c]) < mHigh[c]) r[c] = 1'b1;
    return r;
  endfunction

  function automatic logic expLocked(input int t);
    int maxPh;
    maxPh = 0;
    for (int c = 0; c < CH; c++) if (mPhase[c] > maxPh) maxPh = mPhase[c];
    return t >= maxPh + 1 + 16;
  endfunction

  task automatic runChecks(input int n);
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("clkout t=%0d", tAlign), 32'(CLKOUT), 32'(expClk(tAlign)));
      checkOutput($sformatf("locked t=%0d", tAlign), 32'(LOCKED), 32'(expLocked(tAlign)));
      tick();
    end
  endtask

  task automatic applyStimulus(input logic [6:0] addr, input logic we, input logic [15:0] data);
    DADDR = addr;
    DWE   = we;
    DI    = data;
    DEN   = 1'b1;
    tick();
    DEN   = 1'b0;
    DWE   = 1'b0;
  endtask

  task automatic drpRead(input logic [6:0] addr, input logic [15:0] exp);
    applyStimulus(addr, 1'b0, 16'h0);
    checkOutput($sformatf("rd drdy a=%0h", addr), 32'(DRDY), 32'd1);
    checkOutput($sformatf("rd data a=%0h", addr), 32'(DO), 32'(exp));
    tick();
    checkOutput("rd drdy drop", 32'(DRDY), 32'd0);
    checkOutput("rd do idle", 32'(DO), 32'd0);
  endtask

  task automatic drpWrite(input logic [6:0] addr, input logic [15:0] data);
    applyStimulus(addr, 1'b1, data);
    checkOutput($sformatf("wr drdy a=%0h", addr), 32'(DRDY), 32'd1);
    checkOutput("wr do zero", 32'(DO), 32'd0);
    tick();
    checkOutput("wr drdy drop", 32'(DRDY), 32'd0);
  endtask

  initial begin
    RST = 1'b0; PWRDWN = 1'b0; DEN = 1'b0; DWE = 1'b0; DADDR = '0; DI = '0;
    for (int c = 0; c < CH; c++) begin
      mDiv[c] = 4; mHigh[c] = 2; mPhase[c] = 0;
    end

    repeat (3) tick();
    checkOutput("reset clkout", 32'(CLKOUT), 32'd0);
    checkOutput("reset locked", 32'(LOCKED), 32'd0);
    checkOutput("reset drdy", 32'(DRDY), 32'd0);
    checkOutput("reset do", 32'(DO), 32'd0);

    // Release reset: first edge enters ALIGN
    RST = 1'b1;
    tick();
    tAlign = 0;
    runChecks(24);

`ifdef CLKOUT_BANK_DYN_RECONF_EN
    // Back-to-back DEN: second cycle is swallowed, including its write
    DADDR = 7'd0; DWE = 1'b0; DEN = 1'b1;
    tick();
    checkOutput("hs first drdy", 32'(DRDY), 32'd1);
    checkOutput("hs first do", 32'(DO), 32'd4);
    DWE = 1'b1; DI = 16'd7;
    tick();
    checkOutput("hs second drdy", 32'(DRDY), 32'd0);
    checkOutput("hs second do", 32'(DO), 32'd0);
    DEN = 1'b0; DWE = 1'b0;
    tick();
    drpRead(7'd0, 16'd4);
    drpRead(7'h50, 16'd0);
    drpRead(7'd1, 16'd2);

    drpWrite(7'd6, 16'd1);
    drpWrite(7'd7, 16'd9);
    drpRead(7'd6, 16'd2);
    drpRead(7'd7, 16'd1);
    drpWrite(7'd5, 16'd3);
    drpRead(7'd5, 16'd3);
    checkOutput("locked before commit", 32'(LOCKED), 32'd1);

    applyStimulus(7'h7F, 1'b1, 16'h0);
    checkOutput("commit drdy", 32'(DRDY), 32'd1);
    checkOutput("commit locked drop", 32'(LOCKED), 32'd0);
    mDiv[2] = 2; mHigh[2] = 1; mPhase[1] = 3;
    tAlign = 0;
    runChecks(30);
`else
    for (int i = 0; i < 8; i++) begin
      DADDR = (i == 0) ? 7'h7F : 7'(i);
      DWE   = 1'b1;
      DI    = 16'h0001;
      DEN   = 1'b1;
      tick();
      checkOutput($sformatf("nodrp drdy %0d", i), 32'(DRDY), 32'd0);
      checkOutput($sformatf("nodrp do %0d", i), 32'(DO), 32'd0);
    end
    DEN = 1'b0; DWE = 1'b0;
    runChecks(6);
`endif

    PWRDWN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput($sformatf("pwrdwn clkout %0d", i), 32'(CLKOUT), 32'd0);
      checkOutput($sformatf("pwrdwn locked %0d", i), 32'(LOCKED), 32'd0);
    end
    PWRDWN = 1'b0;
    tick();
    tAlign = 0;
    runChecks(30);

    // Access coinciding with reset must not complete
    DADDR = 7'd5; DWE = 1'b0; DEN = 1'b1; RST = 1'b0;
    tick();
    checkOutput("rst abort drdy", 32'(DRDY), 32'd0);
    DEN = 1'b0;
    tick();
    checkOutput("rst abort drdy2", 32'(DRDY), 32'd0);
    checkOutput("rst clkout", 32'(CLKOUT), 32'd0);
    checkOutput("rst locked", 32'(LOCKED), 32'd0);
    RST = 1'b1;
`ifdef CLKOUT_BANK_DYN_RECONF_EN
    drpRead(7'd5, 16'd0);
    drpRead(7'd6, 16'd4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
